// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions used by the SRAM slave and the master-side bridge.
//   - HTRANS / HSIZE / HRESP encodings
//   - slave data-phase state enum
//   - lane_enable(): little-endian byte-lane decode from address and size
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StErr1,
        StErr2
    } slave_state_e;

    // Byte-lane write enables for an aligned transfer; illegal sizes enable nothing.
    function automatic logic [3:0] lane_enable(input logic [1:0] addr, input logic [2:0] size);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sram_bytewe.sv
// MEM_WORDS x 32 RAM with per-byte write enables.
//   clk   : write clock (rising edge)
//   addr  : word address, shared by read and write
//   wdata : write data, lane i = wdata[8*i+7:8*i]
//   be    : byte write enables, one per lane
//   rdata : asynchronous read of mem[addr]
// Kept behind this boundary so it can be replaced by a technology macro.
module sram_bytewe #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate in front of a word-organised data RAM.
//   clk, reset          : clock, asynchronous active-low reset
//   HSEL/HADDR/HTRANS/  : address phase, sampled when HREADY is high
//   HSIZE/HWRITE
//   HWDATA              : write data, held for the whole data phase
//   HREADY              : bus-level ready
//   HRDATA              : read data, non-zero only in a read completion cycle
//   HREADYOUT, HRESP    : data-phase completion and response
// Legal transfers complete WAIT_STATES+1 cycles after the address phase; illegal
// ones (bad size, misaligned, out of range) get the two-cycle ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    slave_state_e     state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic             pend_q, pend_d;    // completion cycle of a legal transfer
    logic [IDX_W+1:0] addr_q, addr_d;
    logic [2:0]       size_q, size_d;
    logic             write_q, write_d;

    logic             accept;
    logic             addr_err;
    logic [3:0]       be;
    logic [31:0]      mem_rdata;

    // Only NONSEQ/SEQ are accepted, and only while this slave is not stalling.
    assign accept = HSEL && HREADY && HREADYOUT &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    always_comb begin
        addr_err = 1'b0;
        case (HSIZE)
            HSIZE_BYTE: addr_err = 1'b0;
            HSIZE_HALF: addr_err = HADDR[0];
            HSIZE_WORD: addr_err = |HADDR[1:0];
            default:    addr_err = 1'b1;
        endcase
        // Upper address bits matter only here; the RAM index is truncated.
        if ({2'b00, HADDR[31:2]} >= 32'(MEM_WORDS)) begin
            addr_err = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pend_d     = 1'b0;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        HRDATA     = 32'h0;
        be         = 4'b0000;

        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    if (write_q) begin
                        be = lane_enable(addr_q[1:0], size_q);
                    end else begin
                        HRDATA = mem_rdata;
                    end
                end
            end
            StWait: begin
                HREADYOUT = 1'b0;
                if (wait_cnt_q == 4'd0) begin
                    state_d = StIdle;
                    pend_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = StErr2;
            end
            StErr2: begin
                HRESP   = HRESP_ERROR;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A new address phase overlaps the completion cycle or ERR2.
        if (accept) begin
            addr_d  = HADDR[IDX_W+1:0];
            size_d  = HSIZE;
            write_d = HWRITE;
            if (addr_err) begin
                state_d = StErr1;
            end else if (WAIT_STATES == 0) begin
                state_d = StIdle;
                pend_d  = 1'b1;
            end else begin
                state_d    = StWait;
                wait_cnt_d = 4'(WAIT_STATES - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            pend_q     <= 1'b0;
            addr_q     <= '0;
            size_q     <= 3'b000;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
        end
    end

    sram_bytewe #(
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk   (clk),
        .addr  (addr_q[IDX_W+1:2]),
        .wdata (HWDATA),
        .be    (be),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Three slaves (0, 3 and 2 wait states) share one driven bus; only the slave
// indexed by 'cur' is selected. A transaction-level model pushes the expected
// per-cycle data-phase outputs of each accepted transfer into a queue; the
// compare process checks every DUT on every falling edge.
module tb_ahb_sram_slave;

    localparam int MW = 1024;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        logic        is_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel_bus = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'b000;
    logic        hwrite = 1'b0;
    logic [31:0] hwdata = 32'h0;
    int          cur = 0;

    logic [2:0]  hsel_v;
    logic [2:0]  rdy_v;
    logic [2:0]  resp_v;
    logic [31:0] rd_v [3];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          low_cnt = 0;
    logic [31:0] last_rd = 32'h0;
    exp_t        expq[$];
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    assign hsel_v[0] = hsel_bus && (cur == 0);
    assign hsel_v[1] = hsel_bus && (cur == 1);
    assign hsel_v[2] = hsel_bus && (cur == 2);

    ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .HSEL(hsel_v[0]), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy_v[0]),
        .HRDATA(rd_v[0]), .HREADYOUT(rdy_v[0]), .HRESP(resp_v[0])
    );
    ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset(rst_n), .HSEL(hsel_v[1]), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy_v[1]),
        .HRDATA(rd_v[1]), .HREADYOUT(rdy_v[1]), .HRESP(resp_v[1])
    );
    ahb_sram_slave #(.MEM_WORDS(MW), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .reset(rst_n), .HSEL(hsel_v[2]), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdy_v[2]),
        .HRDATA(rd_v[2]), .HREADYOUT(rdy_v[2]), .HRESP(resp_v[2])
    );

    function automatic exp_t mk(input logic rdy, input logic resp, input logic [31:0] data,
                                input logic is_rd);
        exp_t e;
        e.rdy   = rdy;
        e.resp  = resp;
        e.data  = data;
        e.is_rd = is_rd;
        return e;
    endfunction

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare of every slave against the model.
    always @(negedge clk) begin
        cycle++;
        if (rst_n) begin
            exp_t e;
            e = (expq.size() > 0) ? expq.pop_front() : mk(1'b1, 1'b0, 32'h0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                exp_t ee;
                ee = (k == cur) ? e : mk(1'b1, 1'b0, 32'h0, 1'b0);
                n_checks++;
                if ({rdy_v[k], resp_v[k], rd_v[k]} !== {ee.rdy, ee.resp, ee.data}) begin
                    n_fail++;
                    $display("FAIL cycle%0d dut%0d: got rdy=%b resp=%b rdata=%h, expected rdy=%b resp=%b rdata=%h",
                             cycle, k, rdy_v[k], resp_v[k], rd_v[k], ee.rdy, ee.resp, ee.data);
                end
            end
            if (!rdy_v[cur]) low_cnt++;
            if (e.rdy && e.is_rd) last_rd = rd_v[cur];
        end
    end

    // Expected data phase of one accepted transfer, from the bus rules.
    task automatic model_accept(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                                input logic [31:0] wd, input bit commit);
        bit          err;
        int          nb;
        int          start;
        int          key;
        logic [31:0] w;
        err = (sz > 3'd2);
        if (!err) begin
            nb  = 1 << sz;
            err = ((int'(a[1:0]) % nb) != 0) || (int'(a[31:2]) >= MW) || (a[31] == 1'b1);
        end
        if (err) begin
            expq.push_back(mk(1'b0, 1'b1, 32'h0, 1'b0));
            expq.push_back(mk(1'b1, 1'b1, 32'h0, 1'b0));
            return;
        end
        for (int i = 0; i < ws_of(cur); i++) expq.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0));
        key = cur * 65536 + int'(a[31:2]);
        w   = mdl.exists(key) ? mdl[key] : 32'h0;
        if (wr) begin
            start = int'(a[1:0]);
            for (int l = 0; l < 4; l++) begin
                if (l >= start && l < start + nb) w[8*l +: 8] = wd[8*l +: 8];
            end
            if (commit) mdl[key] = w;
            expq.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0));
        end else begin
            expq.push_back(mk(1'b1, 1'b0, w, 1'b1));
        end
    endtask

    // Drive an address phase, hold it until accepted, then supply write data.
    task automatic xfer(input logic sel, input logic [31:0] a, input logic [1:0] tr,
                        input logic [2:0] sz, input logic wr, input logic [31:0] wd,
                        input bit commit = 1'b1);
        int n;
        hsel_bus = sel;
        haddr    = a;
        htrans   = tr;
        hsize    = sz;
        hwrite   = wr;
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy_v[cur]) break;
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL hready_timeout: got 0 for 50 cycles, expected 1");
                break;
            end
        end
        @(posedge clk);
        if (sel && tr[1]) model_accept(a, sz, wr, wd, commit);
        #1;
        hwdata   = wd;
        hsel_bus = 1'b0;
        htrans   = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(expq.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        for (int k = 0; k < 3; k++) begin
            check("reset_hreadyout", {31'h0, rdy_v[k]}, 32'd1);
            check("reset_hresp", {31'h0, resp_v[k]}, 32'd0);
            check("reset_hrdata", rd_v[k], 32'h0);
        end
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero wait states: write then back-to-back read.
        cur = 0;
        low_cnt = 0;
        xfer(1, 32'h10, 2'b10, 3'b010, 1, 32'hDEADBEEF);
        xfer(1, 32'h10, 2'b10, 3'b010, 0, 32'h0);
        drain();
        check("raw_rdata", last_rd, 32'hDEADBEEF);
        check("ws0_no_stall", 32'(low_cnt), 32'd0);

        // Byte and halfword merge into a word.
        xfer(1, 32'h20, 2'b10, 3'b010, 1, 32'h11223344);
        xfer(1, 32'h22, 2'b11, 3'b000, 1, 32'h00AA0000);
        xfer(1, 32'h20, 2'b11, 3'b001, 1, 32'h00005566);
        xfer(1, 32'h20, 2'b10, 3'b010, 0, 32'h0);
        drain();
        check("lane_merge", last_rd, 32'h11AA5566);

        // IDLE, BUSY and deselected transfers interleaved with legal ones.
        xfer(1, 32'h30, 2'b10, 3'b010, 1, 32'h0BADF00D);
        xfer(1, 32'h20, 2'b00, 3'b010, 1, 32'hFFFFFFFF);
        xfer(1, 32'h20, 2'b01, 3'b010, 1, 32'hFFFFFFFF);
        xfer(0, 32'h20, 2'b10, 3'b010, 1, 32'hFFFFFFFF);
        xfer(1, 32'h30, 2'b10, 3'b010, 0, 32'h0);
        drain();
        check("legal_between_idle", last_rd, 32'h0BADF00D);
        xfer(1, 32'h20, 2'b10, 3'b010, 0, 32'h0);
        drain();
        check("idle_busy_nosel_no_write", last_rd, 32'h11AA5566);

        // Illegal transfers: misaligned word/half, bad size, out of range.
        xfer(1, 32'h00, 2'b10, 3'b010, 1, 32'hCAFEBABE);
        xfer(1, 32'h02, 2'b10, 3'b010, 1, 32'hFFFFFFFF);
        xfer(1, 32'h04, 2'b10, 3'b011, 1, 32'hFFFFFFFF);
        xfer(1, 32'h1000, 2'b10, 3'b010, 1, 32'hFFFFFFFF);
        xfer(1, 32'h01, 2'b10, 3'b001, 1, 32'hFFFFFFFF);
        xfer(1, 32'h1000, 2'b10, 3'b000, 1, 32'hFFFFFFFF);
        xfer(1, 32'h00, 2'b10, 3'b010, 0, 32'h0);
        drain();
        check("error_no_write", last_rd, 32'hCAFEBABE);

        // Three wait states, single and pipelined reads.
        cur = 1;
        xfer(1, 32'h04, 2'b10, 3'b010, 1, 32'hA5A55A5A);
        drain();
        low_cnt = 0;
        xfer(1, 32'h04, 2'b10, 3'b010, 0, 32'h0);
        drain();
        check("ws3_low_cycles", 32'(low_cnt), 32'd3);
        check("ws3_rdata", last_rd, 32'hA5A55A5A);
        low_cnt = 0;
        xfer(1, 32'h04, 2'b10, 3'b010, 0, 32'h0);
        xfer(1, 32'h04, 2'b11, 3'b010, 0, 32'h0);
        drain();
        check("ws3_pipelined_low_cycles", 32'(low_cnt), 32'd6);

        // Reset during the wait of a two-wait-state write.
        cur = 2;
        xfer(1, 32'h08, 2'b10, 3'b010, 1, 32'h12345678);
        drain();
        xfer(1, 32'h08, 2'b10, 3'b010, 1, 32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        check("ws2_stalled", {31'h0, rdy_v[2]}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_hreadyout", {31'h0, rdy_v[2]}, 32'd1);
        check("async_reset_hresp", {31'h0, resp_v[2]}, 32'd0);
        check("async_reset_hrdata", rd_v[2], 32'h0);
        expq.delete();
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(1, 32'h08, 2'b10, 3'b010, 0, 32'h0);
        drain();
        check("reset_drops_write", last_rd, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite subordinate (responder) that provides word-organised on-chip data RAM behind the RISC-V subsystem's AHB master port. It takes pipelined address/data-phase transfers and supports byte, halfword and word writes through little-endian byte lanes. Wait states are programmable. Illegal transfers get the standard two-cycle ERROR response.

Parameters:
MEM_WORDS, 1024, depth in 32-bit words; must be a power of two.
WAIT_STATES, 0, data-phase wait cycles inserted before completion (0..15).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
HSEL  input  1  slave select from the address decoder.
HADDR  input  32  byte address, address phase.
HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
HSIZE  input  3  000 byte, 001 halfword, 010 word.
HWRITE  input  1  1 = write.
HWDATA  input  32  write data; valid for the whole data phase.
HREADY  input  1  bus-level ready; qualifies the address phase.
HRDATA  output  32  read data.
HREADYOUT  output  1  this slave's data-phase completion.
HRESP  output  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0, latched phase registers cleared. RAM contents are not reset.
- Address phase accept:
  - Condition: HSEL && HTRANS[1] && HREADY at a rising edge.
  - Latched: HADDR, HSIZE, HWRITE and an error flag.
- Error flag is set for any of:
  - HSIZE > 010;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]≠00;
  - HADDR[31:2] ≥ MEM_WORDS.
- IDLE/BUSY transfers and HSEL=0 are not accepted. The slave stays in IDLE, or returns to it, with HREADYOUT=1 and HRESP=0, and performs no access.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on a legal accept go to WAIT, or straight to a completing data phase if WAIT_STATES=0. On an errored accept go to ERR1.
  - WAIT: HREADYOUT=0 for WAIT_STATES cycles (counter runs from WAIT_STATES-1 down to 0). The next cycle is the completion cycle: HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1, one cycle, then ERR2.
  - ERR2: HREADYOUT=1, HRESP=1, one cycle; no RAM access.
- Latency: a legal transfer completes WAIT_STATES+1 cycles after its address phase. With WAIT_STATES=0 that is the cycle immediately after.
- Write: performed at the edge ending the completion cycle, using that cycle's HWDATA. Byte-lane enables are decoded from latched addr[1:0] and size:
  - byte: lane addr[1:0];
  - halfword: lanes {addr[1],0} and {addr[1],1};
  - word: all 4 lanes.
  - Data is taken from the matching HWDATA lanes (no replication assumed); unselected lanes are unchanged.
- Read: HRDATA = mem[latched addr[31:2]] (full word) during the completion cycle. HRDATA=0 in every other cycle, including ERR1/ERR2 and write completions.
- Pipelining: a new address phase may be accepted in the completion cycle and in ERR2, because HREADY=1 there. It is never accepted while HREADYOUT=0.
- Read-after-write back-to-back: the write commits before the following read's completion cycle, so the read returns the new data. No forwarding path is needed.
- Reset mid-transfer: the transfer is abandoned, a pending write is dropped, and outputs return to reset values.
- Address bits above log2(MEM_WORDS)+2 take part only in the range check.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE codes (BYTE/HALF/WORD);
  - HRESP codes;
  - the slave state enum.
- The master-side bridge reuses the same package.
- One sub-module is natural: sram_bytewe (MEM_WORDS x 32 RAM, 4-bit byte write enable, synchronous write, asynchronous read), so it can later be swapped for a technology macro.

Test Plan:
- WAIT_STATES=0, word write 0xDEADBEEF to 0x10, then a back-to-back read of 0x10 -> HREADYOUT stays 1; HRDATA=0xDEADBEEF in the read's data phase.
- Word 0x11223344 at 0x20, then a byte write 0xAA to 0x22 (data on HWDATA[23:16]) and a halfword write 0x5566 to 0x20 -> read 0x20 returns 0x11AA5566.
- WAIT_STATES=3, read 0x04 -> HREADYOUT low exactly 3 cycles, then high with data; a second NONSEQ accepted in the completion cycle also sees 3 waits.
- Word write to 0x02, then HSIZE=011, then address MEM_WORDS*4 -> each gives HREADYOUT 0/1 with HRESP 1/1 over two cycles; memory unchanged; the next legal transfer returns OKAY.
- IDLE, BUSY and HSEL=0 transfers interleaved with legal ones -> no RAM change, HREADYOUT=1, HRESP=0.
- reset asserted during a WAIT_STATES=2 write wait -> outputs reset immediately and asynchronously; target word keeps its old value.
